// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART frame controller: FSM state encodings,
// the default frame start marker and the timeout counter width.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_CHK   = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         TMR_W         = 24;

endpackage

// File: rtl/uart_timeout_timer.sv
// uart_timeout_timer
// Inter-byte gap timer. Counts enabled cycles since the last clear and
// flags the cycle on which the count sits at LIMIT-1.
// Ports:
//   clk, rst_n  system clock, async active-low reset
//   clear       zero the count; also suppresses expire this cycle
//   enable      advance the count
//   expire      combinational one-cycle pulse at count LIMIT-1
module uart_timeout_timer
  import uart_pkg::*;
#(
  parameter int LIMIT = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(LIMIT - 1);

  logic [TMR_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + TMR_W'(1);
    end
  end

  // Gated by clear so a byte accepted on the expiry cycle beats the timeout.
  assign expire = enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl
// Frame controller behind the UART receiver. Assembles SYNC/ADDR/DATA/CHK
// frames, checks the XOR checksum and the inter-byte timeout, and issues a
// single-cycle register write for each good frame.
//
// state   | meaning
// S_IDLE  | hunting for SYNC_BYTE, other bytes dropped silently
// S_ADDR  | waiting for the address byte
// S_DATA  | waiting for the data byte
// S_CHK   | waiting for the checksum byte (ADDR^DATA)
// S_WRITE | one-cycle write strobe, receiver held off
//
// Ports:
//   clk, rst_n           system clock, async active-low reset
//   rx_data/_valid       byte from the UART receiver
//   rx_data_ready        byte accepted when valid && ready
//   reg_addr/reg_wdata   last successfully written address/data
//   reg_wr               one-cycle write strobe
//   frame_err            one-cycle pulse on checksum error or timeout
//   err_cnt              saturating frame error count
module uart_frame_ctrl
  import uart_pkg::*;
#(
  parameter int         CLK_FRE    = 50,
  parameter int         TIMEOUT_US = 1000,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_data_valid,
  output logic       rx_data_ready,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  output logic       frame_err,
  output logic [7:0] err_cnt
);

  localparam int TIMEOUT_CYCLES = CLK_FRE * TIMEOUT_US;

  state_t     state_q, state_d;
  logic [7:0] addr_q, data_q;
  logic       byte_acc;
  logic       wr_set, err_set;
  logic       tmr_clear, tmr_en, tmr_expire;

  assign byte_acc  = rx_data_valid && rx_data_ready;
  assign tmr_en    = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_CHK);
  assign tmr_clear = byte_acc || (state_q == S_IDLE) || (state_q == S_WRITE);

  uart_timeout_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .expire (tmr_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wr_set  = 1'b0;
    err_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (byte_acc && (rx_data == SYNC_BYTE)) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (byte_acc) begin
          state_d = S_DATA;
        end else if (tmr_expire) begin
          state_d = S_IDLE;
          err_set = 1'b1;
        end
      end
      S_DATA: begin
        if (byte_acc) begin
          state_d = S_CHK;
        end else if (tmr_expire) begin
          state_d = S_IDLE;
          err_set = 1'b1;
        end
      end
      S_CHK: begin
        if (byte_acc) begin
          if (rx_data == (addr_q ^ data_q)) begin
            state_d = S_WRITE;
            wr_set  = 1'b1;
          end else begin
            state_d = S_IDLE;
            err_set = 1'b1;
          end
        end else if (tmr_expire) begin
          state_d = S_IDLE;
          err_set = 1'b1;
        end
      end
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Partial-frame capture; only copied to the outputs when the checksum passes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      data_q <= '0;
    end else if (byte_acc) begin
      if (state_q == S_ADDR) addr_q <= rx_data;
      if (state_q == S_DATA) data_q <= rx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_ready <= 1'b0;
      reg_wr        <= 1'b0;
      reg_addr      <= '0;
      reg_wdata     <= '0;
      frame_err     <= 1'b0;
      err_cnt       <= '0;
    end else begin
      // Registered from the next state so ready is low exactly during S_WRITE.
      rx_data_ready <= (state_d != S_WRITE);
      reg_wr        <= wr_set;
      frame_err     <= err_set;
      if (wr_set) begin
        reg_addr  <= addr_q;
        reg_wdata <= data_q;
      end
      if (err_set && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
module tb_uart_frame_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_data_ready;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr;
  logic       frame_err;
  logic [7:0] err_cnt;

  int errors = 0;
  int checks = 0;
  int exp_err = 0;
  int err_seen = 0;
  logic [15:0] sb_q[$];

  uart_frame_ctrl #(
    .CLK_FRE    (1),
    .TIMEOUT_US (20),
    .SYNC_BYTE  (8'hA5)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_data_ready (rx_data_ready),
    .reg_addr      (reg_addr),
    .reg_wdata     (reg_wdata),
    .reg_wr        (reg_wr),
    .frame_err     (frame_err),
    .err_cnt       (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sat_cnt(input int n);
    return (n > 255) ? 255 : n;
  endfunction

  // Scoreboard: each reg_wr pulse must match the oldest pushed write.
  always @(negedge clk) begin
    logic [15:0] exp_w;
    if (rst_n) begin
      if (reg_wr) begin
        check_eq("wr_expected", {31'b0, sb_q.size() != 0}, 32'd1);
        if (sb_q.size() != 0) begin
          exp_w = sb_q.pop_front();
          check_eq("wr_addr", reg_addr, exp_w[15:8]);
          check_eq("wr_data", reg_wdata, exp_w[7:0]);
        end
      end
      if (frame_err) err_seen++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    rx_data = b;
    rx_data_valid = 1'b1;
    n = 0;
    while (!rx_data_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rx_data_ready) check_eq("rdy_timeout", rx_data_ready, 1);
    @(posedge clk);
    #1 rx_data_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
    send_byte(8'hA5);
    send_byte(a);
    send_byte(d);
    send_byte(c);
  endtask

  task automatic settle_and_check(input string tag);
    repeat (3) @(negedge clk);
    check_eq({tag, "_sb_left"}, sb_q.size(), 0);
    check_eq({tag, "_err_pulses"}, err_seen, exp_err);
    check_eq({tag, "_err_cnt"}, err_cnt, sat_cnt(exp_err));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, rx_data_ready, 0);
    check_eq({tag, "_addr"}, reg_addr, 0);
    check_eq({tag, "_wdata"}, reg_wdata, 0);
    check_eq({tag, "_wr"}, reg_wr, 0);
    check_eq({tag, "_ferr"}, frame_err, 0);
    check_eq({tag, "_ecnt"}, err_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    rx_data = 8'h00;
    rx_data_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1 check_eq("rdy_after_rst", rx_data_ready, 1);

    // Good frame, then back-to-back a frame preceded by junk.
    sb_q.push_back({8'h10, 8'h3C});
    send_frame(8'h10, 8'h3C, 8'h2C);
    sb_q.push_back({8'h01, 8'h02});
    send_byte(8'h00);
    send_byte(8'hFF);
    send_frame(8'h01, 8'h02, 8'h03);
    settle_and_check("good");

    // Bad checksum: outputs hold the last write.
    send_frame(8'h10, 8'h3C, 8'h2D);
    exp_err++;
    settle_and_check("badchk");
    check_eq("badchk_addr_hold", reg_addr, 8'h01);
    check_eq("badchk_wdata_hold", reg_wdata, 8'h02);

    // Timeout after A5,20: error lands at gap cycle 20.
    send_byte(8'hA5);
    send_byte(8'h20);
    repeat (20) @(negedge clk);
    check_eq("to_early", frame_err, 0);
    @(negedge clk);
    check_eq("to_fire", frame_err, 1);
    exp_err++;
    sb_q.push_back({8'h30, 8'h44});
    send_frame(8'h30, 8'h44, 8'h74);
    settle_and_check("timeout");

    // Byte accepted exactly on the expiry cycle wins.
    sb_q.push_back({8'h20, 8'h55});
    send_byte(8'hA5);
    send_byte(8'h20);
    repeat (19) @(negedge clk);
    send_byte(8'h55);
    send_byte(8'h75);
    settle_and_check("edge");

    // Sync byte as payload: address A5 is ordinary data.
    sb_q.push_back({8'hA5, 8'h5A});
    send_frame(8'hA5, 8'h5A, 8'hFF);
    settle_and_check("syncpay");

    // Reset mid-frame discards the partial frame.
    send_byte(8'hA5);
    send_byte(8'h10);
    @(negedge clk);
    rst_n = 1'b0;
    exp_err = 0;
    err_seen = 0;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    send_byte(8'h3C);
    send_byte(8'h2C);
    settle_and_check("postrst");
    check_eq("postrst_addr", reg_addr, 8'h00);
    sb_q.push_back({8'h66, 8'h77});
    send_frame(8'h66, 8'h77, 8'h11);
    settle_and_check("postrst_frame");

    // Saturation of the error counter.
    for (int i = 0; i < 256; i++) begin
      send_frame(8'(i), 8'h00, ~8'(i));
      exp_err++;
    end
    settle_and_check("sat");
    check_eq("sat_addr_hold", reg_addr, 8'h66);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_frame_ctrl.md
# uart_frame_ctrl

Frame-level controller placed directly behind the UART receiver. It drives the receiver's `rx_data_ready` handshake, assembles 4-byte command frames (SYNC, ADDR, DATA, CHK), validates them with an XOR checksum and an inter-byte timeout, and issues single-cycle register-write strobes to the board's control register file. Malformed or stalled frames are dropped, flagged and counted.

## Interface
- `CLK_FRE`, 50: clock frequency in MHz.
- `TIMEOUT_US`, 1000: maximum gap between bytes of one frame, in µs.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `clk` in 1: system clock.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `rx_data` in 8: byte from the UART receiver.
- `rx_data_valid` in 1: receiver byte valid.
- `rx_data_ready` out 1: controller accepts the byte.
- `reg_addr` out 8: write address.
- `reg_wdata` out 8: write data.
- `reg_wr` out 1: one-cycle write strobe.
- `frame_err` out 1: one-cycle pulse on checksum error or timeout.
- `err_cnt` out 8: saturating count of frame errors.

## Operation
- Byte accepted when `rx_data_valid && rx_data_ready` on a rising edge.
- States:
  - S_IDLE: a byte equal to SYNC_BYTE goes to S_ADDR. Any other byte is discarded silently, with no error.
  - S_ADDR: captures the address byte, then goes to S_DATA.
  - S_DATA: captures the data byte, then goes to S_CHK.
  - S_CHK: if the byte equals ADDR^DATA, go to S_WRITE. Otherwise pulse `frame_err` and go to S_IDLE.
  - S_WRITE: one cycle. `reg_wr`=1, then return to S_IDLE.
- `rx_data_ready` is 1 in every state except S_WRITE and during reset.
- Timeout:
  - TIMEOUT_CYCLES = CLK_FRE*TIMEOUT_US, held in a 24-bit counter.
  - The counter clears on every accepted byte and while in S_IDLE or S_WRITE. It increments in S_ADDR, S_DATA and S_CHK.
  - When it reaches TIMEOUT_CYCLES-1 with no byte accepted that cycle: pulse `frame_err` and go to S_IDLE.
- Priority: if a byte is accepted in the same cycle the timeout would fire, the byte wins and no timeout occurs.
- SYNC_BYTE received in S_ADDR, S_DATA or S_CHK is treated as ordinary payload. There is no resync.
- `err_cnt` increments on each `frame_err` pulse and saturates at 255. It never wraps.
- Reset mid-frame: the partial frame is discarded, the FSM returns to S_IDLE and all outputs take their reset values.

## Timing
- Reset values: `rx_data_ready`=0, `reg_addr`=0, `reg_wdata`=0, `reg_wr`=0, `frame_err`=0, `err_cnt`=0.
- `rx_data_ready` rises on the first clock after reset release.
- All outputs are registered.
- Write timing:
  - `reg_wr` is high for exactly one cycle, the cycle after the CHK byte is accepted.
  - `reg_addr` and `reg_wdata` update on that same edge.
  - They hold until the next successful write. Failed frames never change them.
- `frame_err` is high for one cycle, the cycle after the failing byte or timeout event. `err_cnt` updates on the same edge.
- Back-to-back frames: the S_WRITE bubble is one cycle. This is far shorter than one UART byte time, so no byte is lost at any supported baud.
- The receiver holds `rx_data_valid` until it sees ready. A byte arriving during S_WRITE is accepted the following cycle.

## Structure
- Shared package `uart_pkg` holds:
  - state encodings S_IDLE/S_ADDR/S_DATA/S_CHK/S_WRITE (3-bit);
  - the default SYNC_BYTE;
  - the timeout counter width (24).
- One sub-module, `uart_timeout_timer`:
  - inputs clear, enable;
  - parameter LIMIT;
  - output `expire`, a one-cycle pulse at count LIMIT-1, gated off when clear is asserted.
- FSM, capture registers and error counter live in `uart_frame_ctrl`.

## Test plan
- Frame A5,10,3C,2C → `reg_wr` pulse once with `reg_addr`=0x10, `reg_wdata`=0x3C; `frame_err` stays 0.
- Frame A5,10,3C,2D → `frame_err` pulse, `err_cnt`=1, no `reg_wr`, `reg_addr`/`reg_wdata` unchanged.
- Bytes 00,FF,A5,01,02,03 → leading junk ignored, write addr 0x01 data 0x02, `err_cnt`=0.
- A5,20 then an idle gap of TIMEOUT_CYCLES (use CLK_FRE=1, TIMEOUT_US=20) → `frame_err` at gap cycle 20, then a following full valid frame writes correctly. A byte landing exactly on the expiry cycle → no error.
- 256 bad-checksum frames → `err_cnt` saturates at 255.
- Assert `rst_n` low after A5,10 is received, release, then send 3C,2C → no write. Then a full frame → normal write.
